// File: rtl/pulse_train_generator.sv
// pulse_train_generator: emits a burst of count pulses, each width cycles high, separated by gap low cycles.
// Zero width/gap are clamped to 1 so every pulse has distinct rising and falling edges.
module pulse_train_generator #(
   parameter int W_LEN = 8,
   parameter int W_CNT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [W_LEN-1:0] width,
   input  logic [W_LEN-1:0] gap,
   input  logic [W_CNT-1:0] count,
   input  logic             abort,
   output logic             pulse_out,
   output logic             busy,
   output logic             done
);
   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
   state_t           state_q, state_d;
   logic [W_LEN-1:0] phase_q, phase_d, width_q, width_d, gap_q, gap_d;
   logic [W_CNT-1:0] pulses_q, pulses_d;
   logic             pulse_out_q, pulse_out_d, busy_q, busy_d, done_q, done_d;
   logic             last_phase, finish;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         phase_q     <= '0;
         width_q     <= '0;
         gap_q       <= '0;
         pulses_q    <= '0;
         pulse_out_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         phase_q     <= phase_d;
         width_q     <= width_d;
         gap_q       <= gap_d;
         pulses_q    <= pulses_d;
         pulse_out_q <= pulse_out_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end
   assign last_phase = phase_q == W_LEN'(1);
   // phase_q holds the cycles remaining in the current HIGH/LOW phase, counting down to 1
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      width_d  = width_q;
      gap_d    = gap_q;
      pulses_d = pulses_q;
      finish   = 1'b0;
      case (state_q)
         IDLE: if (start && count != '0) begin
            state_d  = HIGH;
            width_d  = width == '0 ? W_LEN'(1) : width;
            gap_d    = gap == '0 ? W_LEN'(1) : gap;
            pulses_d = count;
            phase_d  = width_d;
         end
         HIGH: if (abort) begin
            state_d = IDLE;
         end else if (last_phase) begin
            finish   = pulses_q == W_CNT'(1);
            state_d  = finish ? IDLE : LOW;
            phase_d  = gap_q;
            pulses_d = pulses_q - W_CNT'(1);
         end else begin
            phase_d = phase_q - W_LEN'(1);
         end
         LOW: if (abort) begin
            state_d = IDLE;
         end else begin
            state_d = last_phase ? HIGH : LOW;
            phase_d = last_phase ? width_q : phase_q - W_LEN'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      pulse_out_d = state_d == HIGH;
      busy_d      = state_d != IDLE;
      done_d      = finish;
   end
   assign pulse_out = pulse_out_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule

// File: tb/tb_pulse_train_generator.sv
// tb_pulse_train_generator: directed tests for pulse_train_generator.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pulse_train_generator;
   logic       clk = 1'b0;
   logic       rst_n, start, abort;
   logic [7:0] width, gap, count;
   logic       pulse_out, busy, done;
   int         pass_cnt = 0;
   int         total_cnt = 0;

   pulse_train_generator #(.W_LEN(8), .W_CNT(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .width(width), .gap(gap),
      .count(count), .abort(abort), .pulse_out(pulse_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; width = '0; gap = '0; count = '0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({pulse_out, busy, done} !== 3'b000)
         $display("FAIL reset got=%b exp=000", {pulse_out, busy, done});
      else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [13:0] ep = 14'b11000110001100;
      logic [13:0] eb = 14'b11111111111100;
      logic [13:0] ed = 14'b00000000000010;
      start = 1'b1; width = 8'd2; gap = 8'd3; count = 8'd3;
      @(negedge clk);
      start = 1'b0; width = 8'd7; gap = 8'd0; count = 8'd1;
      for (int i = 0; i < 14; i++) begin
         total_cnt++;
         if ({pulse_out, busy, done} !== {ep[13-i], eb[13-i], ed[13-i]})
            $display("FAIL basic cyc%0d got=%b exp=%b", i + 1, {pulse_out, busy, done},
                     {ep[13-i], eb[13-i], ed[13-i]});
         else pass_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_clamp();
      logic [4:0] ep = 5'b10100;
      logic [4:0] eb = 5'b11100;
      logic [4:0] ed = 5'b00010;
      int edges = 0;
      logic prev = 1'b0;
      start = 1'b1; width = 8'd0; gap = 8'd0; count = 8'd2;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         total_cnt++;
         if ({pulse_out, busy, done} !== {ep[4-i], eb[4-i], ed[4-i]})
            $display("FAIL clamp cyc%0d got=%b exp=%b", i + 1, {pulse_out, busy, done},
                     {ep[4-i], eb[4-i], ed[4-i]});
         else pass_cnt++;
         if (pulse_out && !prev) edges++;
         prev = pulse_out;
         @(negedge clk);
      end
      total_cnt++;
      if (edges != 2) $display("FAIL clamp_edges got=%0d exp=2", edges);
      else pass_cnt++;
   endtask

   task automatic test_count_zero();
      int bad = 0;
      start = 1'b1; width = 8'd5; gap = 8'd5; count = 8'd0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if ({pulse_out, busy, done} !== 3'b000) bad++;
      end
      start = 1'b0;
      total_cnt++;
      if (bad != 0) $display("FAIL count_zero got=%0d active cycles exp=0", bad);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [8:0] ep = 9'b101010100;
      logic [8:0] eb = 9'b111011100;
      logic [8:0] ed = 9'b000100010;
      start = 1'b1; width = 8'd1; gap = 8'd1; count = 8'd2;
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         total_cnt++;
         if ({pulse_out, busy, done} !== {ep[8-i], eb[8-i], ed[8-i]})
            $display("FAIL back_to_back cyc%0d got=%b exp=%b", i + 1, {pulse_out, busy, done},
                     {ep[8-i], eb[8-i], ed[8-i]});
         else pass_cnt++;
         if (i == 7) start = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_abort();
      logic [8:0] ep = 9'b111100111;
      int bad = 0;
      start = 1'b1; width = 8'd4; gap = 8'd2; count = 8'd5;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         total_cnt++;
         if ({pulse_out, busy, done} !== {ep[8-i], 2'b10})
            $display("FAIL abort_pre cyc%0d got=%b exp=%b", i + 1, {pulse_out, busy, done},
                     {ep[8-i], 2'b10});
         else pass_cnt++;
         if (i == 8) begin abort = 1'b1; start = 1'b1; end
         @(negedge clk);
      end
      abort = 1'b0; start = 1'b0;
      total_cnt++;
      if ({pulse_out, busy, done} !== 3'b000)
         $display("FAIL abort_next got=%b exp=000", {pulse_out, busy, done});
      else pass_cnt++;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ({pulse_out, busy, done} !== 3'b000) bad++;
      end
      total_cnt++;
      if (bad != 0) $display("FAIL abort_quiet got=%0d active cycles exp=0", bad);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [13:0] ep = 14'b11000110001100;
      logic [13:0] eb = 14'b11111111111100;
      logic [13:0] ed = 14'b00000000000010;
      start = 1'b1; width = 8'd2; gap = 8'd3; count = 8'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({pulse_out, busy, done} !== 3'b010)
         $display("FAIL reset_mid_low got=%b exp=010", {pulse_out, busy, done});
      else pass_cnt++;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      total_cnt++;
      if ({pulse_out, busy, done} !== 3'b000)
         $display("FAIL reset_mid got=%b exp=000", {pulse_out, busy, done});
      else pass_cnt++;
      repeat (3) @(negedge clk);
      total_cnt++;
      if ({pulse_out, busy, done} !== 3'b000)
         $display("FAIL reset_mid_quiet got=%b exp=000", {pulse_out, busy, done});
      else pass_cnt++;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 14; i++) begin
         total_cnt++;
         if ({pulse_out, busy, done} !== {ep[13-i], eb[13-i], ed[13-i]})
            $display("FAIL reset_restart cyc%0d got=%b exp=%b", i + 1, {pulse_out, busy, done},
                     {ep[13-i], eb[13-i], ed[13-i]});
         else pass_cnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_max();
      int hi = 0, bsy = 0, edges = 0;
      logic dn = 1'b0, prev = 1'b0;
      start = 1'b1; width = 8'd255; gap = 8'd0; count = 8'd1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 300 && !dn; i++) begin
         if (done) dn = 1'b1;
         else if (pulse_out) hi++;
         @(negedge clk);
      end
      total_cnt++;
      if (!dn || hi != 255) $display("FAIL max_width got=%0d done=%b exp=255 done=1", hi, dn);
      else pass_cnt++;
      dn = 1'b0;
      start = 1'b1; width = 8'd1; gap = 8'd1; count = 8'd255;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 600 && !dn; i++) begin
         if (done) dn = 1'b1;
         if (busy) bsy++;
         if (pulse_out && !prev) edges++;
         prev = pulse_out;
         @(negedge clk);
      end
      total_cnt++;
      if (!dn || edges != 255) $display("FAIL max_count got=%0d done=%b exp=255 done=1", edges, dn);
      else pass_cnt++;
      total_cnt++;
      if (bsy != 509) $display("FAIL max_count_len got=%0d exp=509", bsy);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_clamp();
      test_count_zero();
      @(negedge clk);
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_max();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
